// File: rtl/motor_duty_controller.sv
// Duty command sequencer: slew-limited duty ramp, stop-before-reverse,
// and latched watchdog / hall-code faults ahead of the phase drivers.
module motor_duty_controller #(
  parameter int DUTY_WIDTH      = 10,
  parameter int RAMP_DIV        = 1000,
  parameter int RAMP_STEP       = 8,
  parameter int WDT_CYCLES      = 500000,
  parameter int HALL_BAD_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DUTY_WIDTH-1:0] cmd_duty,
  input  logic                  cmd_dir,
  input  logic                  cmd_brake,
  input  logic [2:0]            hall,
  input  logic                  clear_fault,
  output logic [DUTY_WIDTH-1:0] duty_out,
  output logic                  dir_out,
  output logic                  brake_out,
  output logic                  fault_wdt,
  output logic                  fault_hall,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    REVERSE = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WDT_W  = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam int HALL_W = $clog2(HALL_BAD_CYCLES + 1);

  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [WDT_W-1:0]    WDT_LAST  = WDT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);
  localparam logic [HALL_W-1:0]   HALL_LAST = HALL_W'(HALL_BAD_CYCLES - 1);
  localparam logic [HALL_W-1:0]   HALL_MAX  = HALL_W'(HALL_BAD_CYCLES);
  localparam logic [DUTY_WIDTH:0] STEP_X    = (DUTY_WIDTH + 1)'(RAMP_STEP);

  // One slew-limited step from cur toward dst, computed one bit wider so the
  // sum cannot wrap and the result never passes dst.
  function automatic logic [DUTY_WIDTH-1:0] ramp_toward(
    input logic [DUTY_WIDTH-1:0] cur,
    input logic [DUTY_WIDTH-1:0] dst
  );
    logic [DUTY_WIDTH:0] cur_x;
    logic [DUTY_WIDTH:0] dst_x;
    logic [DUTY_WIDTH:0] sum_x;
    logic [DUTY_WIDTH:0] gap_x;
    cur_x = {1'b0, cur};
    dst_x = {1'b0, dst};
    sum_x = cur_x + STEP_X;
    gap_x = cur_x - dst_x;
    if (cur_x < dst_x)
      ramp_toward = (sum_x > dst_x) ? dst : sum_x[DUTY_WIDTH-1:0];
    else if (cur_x > dst_x)
      ramp_toward = (gap_x <= STEP_X) ? dst : DUTY_WIDTH'(cur_x - STEP_X);
    else
      ramp_toward = cur;
  endfunction

  state_t                state, state_nxt;
  logic [DUTY_WIDTH-1:0] target, target_nxt;
  logic [DUTY_WIDTH-1:0] duty_nxt;
  logic                  pend_dir, pend_dir_nxt;
  logic                  dir_nxt, brake_nxt, ready_nxt;
  logic                  fault_wdt_nxt, fault_hall_nxt;
  logic [RAMP_W-1:0]     ramp_cnt, ramp_cnt_nxt;
  logic [WDT_W-1:0]      wdt_cnt, wdt_cnt_nxt;
  logic [HALL_W-1:0]     hall_cnt, hall_cnt_nxt;
  logic                  accept, hall_bad, tick, wdt_trip, hall_trip;

  assign state_out = state;
  assign accept    = cmd_valid && cmd_ready;
  assign hall_bad  = (hall == 3'b000) || (hall == 3'b111);
  assign tick      = (ramp_cnt == RAMP_LAST);
  assign wdt_trip  = (WDT_CYCLES > 0) && (state != FAULT) && !accept && (wdt_cnt == WDT_LAST);
  assign hall_trip = hall_bad && (hall_cnt == HALL_LAST);

  always_comb begin
    state_nxt      = state;
    target_nxt     = target;
    duty_nxt       = duty_out;
    dir_nxt        = dir_out;
    pend_dir_nxt   = pend_dir;
    brake_nxt      = brake_out;
    fault_wdt_nxt  = fault_wdt;
    fault_hall_nxt = fault_hall;
    ramp_cnt_nxt   = tick ? '0 : ramp_cnt + 1'b1;
    wdt_cnt_nxt    = wdt_cnt;
    hall_cnt_nxt   = '0;

    if ((WDT_CYCLES > 0) && (state != FAULT))
      wdt_cnt_nxt = accept ? '0 : wdt_cnt + 1'b1;
    if (hall_bad)
      hall_cnt_nxt = (hall_cnt == HALL_MAX) ? hall_cnt : hall_cnt + 1'b1;

    // Faults outrank everything, including a command accepted this cycle.
    if (wdt_trip || hall_trip) begin
      if (wdt_trip)  fault_wdt_nxt  = 1'b1;
      if (hall_trip) fault_hall_nxt = 1'b1;
      state_nxt  = FAULT;
      duty_nxt   = '0;
      target_nxt = '0;
      brake_nxt  = 1'b0;
    end else if (state == FAULT) begin
      if (clear_fault && !hall_bad) begin
        fault_wdt_nxt  = 1'b0;
        fault_hall_nxt = 1'b0;
        wdt_cnt_nxt    = '0;
        hall_cnt_nxt   = '0;
        state_nxt      = IDLE;
      end
    end else if (accept && cmd_brake) begin
      duty_nxt   = '0;
      target_nxt = '0;
      brake_nxt  = 1'b1;
      state_nxt  = IDLE;
    end else if (accept) begin
      target_nxt = cmd_duty;
      brake_nxt  = 1'b0;
      if ((cmd_dir == dir_out) || (duty_out == '0)) begin
        if (duty_out == '0) dir_nxt = cmd_dir;
        state_nxt = (cmd_duty == '0) ? IDLE : RUN;
      end else begin
        pend_dir_nxt = cmd_dir;
        state_nxt    = REVERSE;
      end
    end else if ((state == REVERSE) && (duty_out == '0)) begin
      // Motor is stopped: safe to flip direction, then ramp to the pending target.
      dir_nxt   = pend_dir;
      state_nxt = RUN;
    end else begin
      if ((state == RUN) && (duty_out == '0) && (target == '0))
        state_nxt = IDLE;
      if (tick)
        duty_nxt = ramp_toward(duty_out, (state == REVERSE) ? '0 : target);
    end

    ready_nxt = (state_nxt != FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      target     <= '0;
      duty_out   <= '0;
      dir_out    <= 1'b0;
      pend_dir   <= 1'b0;
      brake_out  <= 1'b0;
      cmd_ready  <= 1'b0;
      fault_wdt  <= 1'b0;
      fault_hall <= 1'b0;
      ramp_cnt   <= '0;
      wdt_cnt    <= '0;
      hall_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      duty_out   <= duty_nxt;
      dir_out    <= dir_nxt;
      pend_dir   <= pend_dir_nxt;
      brake_out  <= brake_nxt;
      cmd_ready  <= ready_nxt;
      fault_wdt  <= fault_wdt_nxt;
      fault_hall <= fault_hall_nxt;
      ramp_cnt   <= ramp_cnt_nxt;
      wdt_cnt    <= wdt_cnt_nxt;
      hall_cnt   <= hall_cnt_nxt;
    end
  end

endmodule

// File: doc/motor_duty_controller.md
# motor_duty_controller

Command sequencer in front of the three per-phase drivers. Accepts duty/direction/brake commands from the host interface over a valid/ready handshake and ramps the applied duty toward the commanded target at a bounded slew rate. It forces a zero-duty stop before any direction reversal and latches faults for command-watchdog expiry and invalid hall codes. Its `duty_out`/`dir_out`/`brake_out` drive the commutation and phase-driver layer in place of a constant duty cycle.

## Interface
- `DUTY_WIDTH`, 10, width of duty values (matches `DUTY_CYCLE_WIDTH`)
- `RAMP_DIV`, 1000, clock cycles per ramp tick (≥1)
- `RAMP_STEP`, 8, maximum duty change per ramp tick (≥1)
- `WDT_CYCLES`, 500000, cycles without an accepted command before a watchdog fault; 0 disables the watchdog
- `HALL_BAD_CYCLES`, 64, consecutive cycles of invalid hall code before a hall fault (≥1)
- `clock`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_duty`  in  DUTY_WIDTH  target duty magnitude
- `cmd_dir`  in  1  target direction (1 = reverse)
- `cmd_brake`  in  1  brake request; `cmd_duty`/`cmd_dir` ignored when set
- `hall`  in  3  synchronized hall code from the hall-sensor block
- `clear_fault`  in  1  single-cycle fault-clear request
- `duty_out`  out  DUTY_WIDTH  applied duty to the phase drivers
- `dir_out`  out  1  applied direction
- `brake_out`  out  1  low-side brake request
- `fault_wdt`  out  1  latched watchdog fault
- `fault_hall`  out  1  latched hall fault
- `state_out`  out  2  current state: 0 IDLE, 1 RUN, 2 REVERSE, 3 FAULT

## Operation
- All outputs are registered. Reset values: state IDLE, `duty_out`=0, `dir_out`=0, `brake_out`=0, `cmd_ready`=0, both faults 0. Target duty and direction reset to 0. All counters reset to 0.
- `cmd_ready` is 1 in every state except FAULT. It becomes 1 on the first edge after reset release.
- A command is accepted when `cmd_valid && cmd_ready` at a rising edge. Acceptance clears the watchdog counter.
- Brake command:
  - `duty_out` and target go to 0 on the next edge, with no ramp.
  - `brake_out` goes to 1. State becomes IDLE.
  - `brake_out` stays 1 until the next accepted non-brake command.
- Drive command with `cmd_dir == dir_out` or `duty_out == 0`:
  - Target ← `cmd_duty`. `dir_out` ← `cmd_dir`, but only if `duty_out == 0`.
  - `brake_out` ← 0. State becomes RUN, or IDLE if `cmd_duty == 0`.
- Drive command with `cmd_dir != dir_out` and `duty_out != 0`:
  - Stores the pending direction and target. State becomes REVERSE.
- REVERSE sequence:
  - Ramp toward 0.
  - On the tick where `duty_out` reaches 0, `dir_out` flips on the following edge.
  - Then state becomes RUN and the ramp continues toward the pending target.
- Ramp tick:
  - A free-running counter 0..RAMP_DIV-1 generates a tick when it equals RAMP_DIV-1.
  - On a tick, if `duty_out < target`: `duty_out ← min(duty_out+RAMP_STEP, target)`.
  - If `duty_out > target`: `duty_out ← max(duty_out−RAMP_STEP, target)`.
  - Arithmetic is done in DUTY_WIDTH+1 bits. The result never overshoots the target and never wraps.
- RUN with `duty_out == target == 0` returns to IDLE.
- Watchdog (WDT_CYCLES>0):
  - The counter increments each cycle outside FAULT when no command is accepted.
  - When the count reaches WDT_CYCLES, `fault_wdt` is set.
- Hall check:
  - `hall` of 3'b000 or 3'b111 increments a bad counter. Any valid code clears it.
  - Reaching HALL_BAD_CYCLES sets `fault_hall`.
- Fault entry:
  - State FAULT, `duty_out` ← 0 immediately (no ramp), target ← 0, `brake_out` ← 0, `cmd_ready` ← 0.
  - `dir_out` is held.
- FAULT exit:
  - `clear_fault`=1 while `hall` is valid clears both fault flags and the watchdog and hall counters. State becomes IDLE.
  - `clear_fault` with an invalid `hall` is ignored.

## Timing
- Brake or fault to `duty_out`=0: 1 cycle.
- Command accept to first duty change: up to RAMP_DIV cycles, since ramp ticks are not realigned to commands.
- Full-scale ramp 0→(2^DUTY_WIDTH−1): ceil((2^DUTY_WIDTH−1)/RAMP_STEP) ticks.
- Watchdog fault flag asserts at edge WDT_CYCLES after the last accepting edge. The state is FAULT on the same edge.
- Simultaneous events, priority order:
  1. reset
  2. fault detection: a command accepted in the same cycle is discarded
  3. brake
  4. drive command
  5. ramp tick
- A new drive command during REVERSE replaces the pending target and direction. If the new direction equals the current `dir_out`, state returns to RUN without reaching 0.
- `reset_n` asserted mid-ramp or mid-reverse: all outputs go to reset values asynchronously.

## Test plan
Bench parameters: DUTY_WIDTH=10, RAMP_DIV=4, RAMP_STEP=16, WDT_CYCLES=200, HALL_BAD_CYCLES=8, `hall`=3'b001.
- Accept duty 100, dir 0 from IDLE. Required: `duty_out` steps 16,32,48,64,80,96,100 on successive ticks 4 cycles apart, then holds; state RUN.
- At `duty_out`=100 dir 0, command duty 40 dir 1. Required:
  - State REVERSE; `duty_out` ramps 84,68,52,36,20,4,0.
  - `dir_out`=1 next edge, then ramp 16,32,40; state RUN.
- At `duty_out`=100, brake command. Required: next edge `duty_out`=0, `brake_out`=1, state IDLE. A later command with duty 20 clears `brake_out`.
- No commands for 200 cycles after an accept at `duty_out`=64. Required:
  - `fault_wdt`=1, `duty_out`=0, `cmd_ready`=0, state FAULT.
  - `clear_fault` → IDLE, `cmd_ready`=1.
- `hall`=3'b111 for 7 cycles then 3'b011: no fault. `hall`=3'b000 for 8 cycles: `fault_hall`=1. `clear_fault` while `hall`=3'b000: fault stays set.
- Assert `reset_n` low mid-ramp at `duty_out`=48. Required: all outputs 0 immediately; `cmd_ready`=1 one edge after release.
